// File: rtl/rasterix_display_pkg.sv
// Shared display-path definitions: pixel format, AXI constants, panel size and width helpers.
package rasterix_display_pkg;

    localparam int         PIXEL_W        = 16;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         PANEL_W        = 480;
    localparam int         PANEL_H        = 320;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to index n entries (0..n-1).
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_CHECK,
        RD_ADDR,
        RD_DRAIN
    } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push on a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo
    import rasterix_display_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                    aclk,
    input  logic                    resetn,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int AW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/framebuffer_stream_reader.sv
// Fetches one RGB565 frame over AXI4 read bursts into a beat FIFO and streams it out
// one pixel per AXIS beat, with tlast on the final pixel of the frame.
module framebuffer_stream_reader
    import rasterix_display_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int BURST_LEN   = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int PIXEL_COUNT = PANEL_W * PANEL_H
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [PIXEL_W-1:0]    m_axis_tdata
);

    localparam int PPB         = DATA_WIDTH / PIXEL_W;
    localparam int TOTAL_BEATS = PIXEL_COUNT * PIXEL_W / DATA_WIDTH;
    localparam int BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int BL_W        = cnt_w(TOTAL_BEATS);
    localparam int LEN_W       = cnt_w(BURST_LEN);
    localparam int OCC_W       = cnt_w(FIFO_DEPTH);
    localparam int SEL_W       = idx_w(PPB);
    localparam int PIX_W       = idx_w(PIXEL_COUNT);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
    } ar_req_t;

    rd_state_t             state;
    ar_req_t               ar_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BL_W-1:0]       beats_left;
    logic [LEN_W-1:0]      len_q;
    logic [OCC_W-1:0]      outstanding;
    logic [31:0]           len_w;
    logic [31:0]           used_w;
    logic                  credit_ok;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [OCC_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_dout;

    logic [PPB-1:0][PIXEL_W-1:0] cur_beat;
    logic [SEL_W-1:0]            pix_sel;
    logic [PIX_W-1:0]            pix_cnt;
    logic                        out_free;
    logic                        more_in_beat;
    logic                        load_pix;
    logic [PIXEL_W-1:0]          next_pix;

    logic ar_hs;
    logic r_hs;
    logic pix_hs;
    logic unused_inputs;

    assign m_axi_araddr  = ar_q.addr;
    assign m_axi_arlen   = ar_q.len;
    assign m_axi_arsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_rready  = !fifo_full;

    assign ar_hs  = m_axi_arvalid && m_axi_arready;
    assign r_hs   = m_axi_rvalid && m_axi_rready;
    assign pix_hs = m_axis_tvalid && m_axis_tready;

    // Beats are counted on arrival, so burst boundaries and error responses don't matter here.
    assign unused_inputs = ^{m_axi_rresp, m_axi_rlast};

    // Credit: FIFO entries already holding data plus beats promised by issued bursts.
    always_comb begin
        len_w     = (32'(beats_left) < 32'(BURST_LEN)) ? 32'(beats_left) : 32'(BURST_LEN);
        used_w    = 32'(fifo_count) + 32'(outstanding);
        credit_ok = (32'(FIFO_DEPTH) - used_w) >= len_w;
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state         <= RD_IDLE;
            busy          <= 1'b0;
            ar_q          <= '0;
            m_axi_arvalid <= 1'b0;
            addr_q        <= '0;
            beats_left    <= '0;
            len_q         <= '0;
            outstanding   <= '0;
        end else begin
            outstanding <= outstanding + (ar_hs ? OCC_W'(len_q) : '0) - OCC_W'(r_hs);
            case (state)
                RD_IDLE: begin
                    if (start) begin
                        addr_q     <= base_addr;
                        beats_left <= BL_W'(TOTAL_BEATS);
                        busy       <= 1'b1;
                        state      <= RD_CHECK;
                    end
                end
                RD_CHECK: begin
                    if (credit_ok) begin
                        ar_q.addr     <= addr_q;
                        ar_q.len      <= 8'(len_w - 32'd1);
                        len_q         <= LEN_W'(len_w);
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        addr_q        <= addr_q + ADDR_WIDTH'(32'(len_q) * 32'(BEAT_BYTES));
                        beats_left    <= beats_left - BL_W'(len_q);
                        state         <= (beats_left == BL_W'(len_q)) ? RD_DRAIN : RD_CHECK;
                    end
                end
                RD_DRAIN: begin
                    if (outstanding == '0 && pix_hs && m_axis_tlast) begin
                        busy  <= 1'b0;
                        state <= RD_IDLE;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_beat_fifo (
        .aclk   (aclk),
        .resetn (resetn),
        .push   (r_hs),
        .din    (m_axi_rdata),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // The next beat is popped in the same cycle its predecessor's last pixel is accepted.
    always_comb begin
        out_free     = !m_axis_tvalid || m_axis_tready;
        more_in_beat = m_axis_tvalid && (pix_sel != SEL_W'(PPB - 1));
        fifo_pop     = out_free && !more_in_beat && !fifo_empty;
        load_pix     = out_free && (more_in_beat || !fifo_empty);
        next_pix     = more_in_beat ? cur_beat[pix_sel + 1'b1] : fifo_dout[PIXEL_W-1:0];
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            cur_beat      <= '0;
            pix_sel       <= '0;
            pix_cnt       <= '0;
        end else if (out_free) begin
            m_axis_tvalid <= load_pix;
            if (load_pix) begin
                m_axis_tdata <= next_pix;
                m_axis_tlast <= (pix_cnt == PIX_W'(PIXEL_COUNT - 1));
                pix_cnt      <= (pix_cnt == PIX_W'(PIXEL_COUNT - 1)) ? '0 : pix_cnt + 1'b1;
                if (more_in_beat) begin
                    pix_sel <= pix_sel + 1'b1;
                end else begin
                    pix_sel  <= '0;
                    cur_beat <= fifo_dout;
                end
            end
        end
    end

endmodule
